mc_controller: RTL and testbench

- Main control unit for the multicycle MIPS core.
- Sequences the shared single-ALU/single-memory datapath through fetch, decode and per-instruction execute states, one state per clock.
- Drives every datapath control input (pcEn, IorD, memwrite, IRwrite, regdst, memtoreg, regwrite, alusrcA, alusrcB, pcsrc, alucontrol) from the current state, the opcode/funct of the latched instruction, and the ALU zero flag.

---
 rtl/mc_controller.sv | 170 +++++++++++++++++
 tb/tb_mc_controller.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Main control FSM for the multicycle MIPS core: one state per clock, all
// datapath strobes decoded combinationally from the current state.
module mc_controller #(
  parameter bit SUPPORT_BNE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcEn,
  output logic       IorD,
  output logic       memwrite,
  output logic       IRwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrcA,
  output logic [1:0] alusrcB,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     r_state;
  state_t     w_next;
  logic       r_illegal;
  logic       w_set_illegal;
  logic       w_funct_ok;
  logic [2:0] w_rtype_alu;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_set_illegal) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_funct_ok  = 1'b1;
    w_rtype_alu = 3'b010;
    case (funct)
      6'b100000: w_rtype_alu = 3'b010;
      6'b100010: w_rtype_alu = 3'b110;
      6'b100100: w_rtype_alu = 3'b000;
      6'b100101: w_rtype_alu = 3'b001;
      6'b101010: w_rtype_alu = 3'b111;
      default:   w_funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    pcEn          = 1'b0;
    IorD          = 1'b0;
    memwrite      = 1'b0;
    IRwrite       = 1'b0;
    regdst        = 1'b0;
    memtoreg      = 1'b0;
    regwrite      = 1'b0;
    alusrcA       = 1'b0;
    alusrcB       = 2'b00;
    pcsrc         = 2'b00;
    alucontrol    = 3'b010;
    w_next        = S_FETCH;
    w_set_illegal = 1'b0;
    case (r_state)
      S_FETCH: begin
        IRwrite = 1'b1;
        alusrcB = 2'b01;
        pcEn    = 1'b1;
        w_next  = S_DECODE;
      end
      S_DECODE: begin
        alusrcB = 2'b11;
        case (op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE: begin
            if (w_funct_ok) w_next = S_RTYPEEX;
            else            w_set_illegal = 1'b1;
          end
          OP_BEQ:  w_next = S_BEQEX;
          OP_BNE: begin
            if (SUPPORT_BNE) w_next = S_BNEEX;
            else             w_set_illegal = 1'b1;
          end
          OP_ADDI: w_next = S_ADDIEX;
          OP_J:    w_next = S_JEX;
          default: w_set_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        alusrcA = 1'b1;
        alusrcB = 2'b10;
        w_next  = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        IorD   = 1'b1;
        w_next = S_MEMWB;
      end
      // Address stays on aluout through writeback so the data register sees a stable read.
      S_MEMWB: begin
        IorD     = 1'b1;
        memtoreg = 1'b1;
        regwrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        memwrite = 1'b1;
      end
      S_RTYPEEX: begin
        alusrcA    = 1'b1;
        alucontrol = w_rtype_alu;
        w_next     = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
      end
      S_BEQEX, S_BNEEX: begin
        alusrcA    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        pcEn       = (r_state == S_BEQEX) ? zero : ~zero;
      end
      S_ADDIEX: begin
        alusrcA = 1'b1;
        alusrcB = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JEX: begin
        pcsrc = 2'b10;
        pcEn  = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  assign illegal = r_illegal;
  assign state   = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Table-driven check of the multicycle control FSM, plus reset and illegal-op sequences.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcEn, IorD, memwrite, IRwrite, regdst, memtoreg, regwrite, alusrcA;
  logic [1:0] alusrcB, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail   = 0;

  mc_controller #(.SUPPORT_BNE(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcEn(pcEn), .IorD(IorD), .memwrite(memwrite), .IRwrite(IRwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrcA(alusrcA), .alusrcB(alusrcB), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, BNE = 6'b000101, ADDI = 6'b001000;
  localparam logic [5:0] JMP = 6'b000010, BAD = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_OR = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010, F_BAD = 6'b111111;

  // Flag byte order: pcEn IorD memwrite IRwrite regdst memtoreg regwrite alusrcA
  function automatic logic [19:0] ev(input logic [3:0] st, input logic [7:0] f,
                                     input logic [1:0] b, input logic [1:0] ps,
                                     input logic [2:0] ac, input logic il);
    return {st, f, b, ps, ac, il};
  endfunction

  function automatic logic [19:0] fetch_e(input logic il);
    return ev(4'd0, 8'b1001_0000, 2'b01, 2'b00, 3'b010, il);
  endfunction
  function automatic logic [19:0] decode_e(input logic il);
    return ev(4'd1, 8'b0000_0000, 2'b11, 2'b00, 3'b010, il);
  endfunction

  wire [19:0] w_act = {state, pcEn, IorD, memwrite, IRwrite, regdst, memtoreg,
                       regwrite, alusrcA, alusrcB, pcsrc, alucontrol, illegal};

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic [19:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input logic [19:0] e);
    vec_t v;
    v.name = nm; v.op = o; v.funct = f; v.zero = z; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic add_fd(input string nm, input logic [5:0] o, input logic [5:0] f,
                        input logic z, input logic il);
    add({nm, "_fetch"},  o, f, z, fetch_e(il));
    add({nm, "_decode"}, o, f, z, decode_e(il));
  endtask

  initial begin
    add_fd("lw", LW, F_ADD, 1'b0, 1'b0);
    add("lw_memadr", LW, F_ADD, 1'b0, ev(4'd2, 8'b0000_0001, 2'b10, 2'b00, 3'b010, 1'b0));
    add("lw_memrd",  LW, F_ADD, 1'b0, ev(4'd3, 8'b0100_0000, 2'b00, 2'b00, 3'b010, 1'b0));
    add("lw_memwb",  LW, F_ADD, 1'b0, ev(4'd4, 8'b0100_0110, 2'b00, 2'b00, 3'b010, 1'b0));
    add_fd("sw", SW, F_ADD, 1'b0, 1'b0);
    add("sw_memadr", SW, F_ADD, 1'b0, ev(4'd2, 8'b0000_0001, 2'b10, 2'b00, 3'b010, 1'b0));
    add("sw_memwr",  SW, F_ADD, 1'b0, ev(4'd5, 8'b0110_0000, 2'b00, 2'b00, 3'b010, 1'b0));
    add_fd("sub", RT, F_SUB, 1'b0, 1'b0);
    add("sub_ex", RT, F_SUB, 1'b0, ev(4'd6, 8'b0000_0001, 2'b00, 2'b00, 3'b110, 1'b0));
    add("sub_wb", RT, F_SUB, 1'b0, ev(4'd7, 8'b0000_1010, 2'b00, 2'b00, 3'b010, 1'b0));
    add_fd("or", RT, F_OR, 1'b1, 1'b0);
    add("or_ex", RT, F_OR, 1'b1, ev(4'd6, 8'b0000_0001, 2'b00, 2'b00, 3'b001, 1'b0));
    add("or_wb", RT, F_OR, 1'b1, ev(4'd7, 8'b0000_1010, 2'b00, 2'b00, 3'b010, 1'b0));
    add_fd("slt", RT, F_SLT, 1'b0, 1'b0);
    add("slt_ex", RT, F_SLT, 1'b0, ev(4'd6, 8'b0000_0001, 2'b00, 2'b00, 3'b111, 1'b0));
    add("slt_wb", RT, F_SLT, 1'b0, ev(4'd7, 8'b0000_1010, 2'b00, 2'b00, 3'b010, 1'b0));
    add_fd("addi", ADDI, F_SUB, 1'b1, 1'b0);
    add("addi_ex", ADDI, F_SUB, 1'b1, ev(4'd9, 8'b0000_0001, 2'b10, 2'b00, 3'b010, 1'b0));
    add("addi_wb", ADDI, F_SUB, 1'b1, ev(4'd10, 8'b0000_0010, 2'b00, 2'b00, 3'b010, 1'b0));
    add_fd("beq_t", BEQ, F_ADD, 1'b1, 1'b0);
    add("beq_taken", BEQ, F_ADD, 1'b1, ev(4'd8, 8'b1000_0001, 2'b00, 2'b01, 3'b110, 1'b0));
    add_fd("beq_n", BEQ, F_ADD, 1'b0, 1'b0);
    add("beq_not", BEQ, F_ADD, 1'b0, ev(4'd8, 8'b0000_0001, 2'b00, 2'b01, 3'b110, 1'b0));
    add_fd("bne_t", BNE, F_ADD, 1'b0, 1'b0);
    add("bne_taken", BNE, F_ADD, 1'b0, ev(4'd12, 8'b1000_0001, 2'b00, 2'b01, 3'b110, 1'b0));
    add_fd("bne_n", BNE, F_ADD, 1'b1, 1'b0);
    add("bne_not", BNE, F_ADD, 1'b1, ev(4'd12, 8'b0000_0001, 2'b00, 2'b01, 3'b110, 1'b0));
    add_fd("j", JMP, F_ADD, 1'b0, 1'b0);
    add("j_ex", JMP, F_ADD, 1'b0, ev(4'd11, 8'b1000_0000, 2'b00, 2'b10, 3'b010, 1'b0));
    add_fd("badop", BAD, F_ADD, 1'b0, 1'b0);
    // Illegal op returns straight to FETCH with the sticky flag now raised.
    add_fd("lw2", LW, F_ADD, 1'b0, 1'b1);
    add("lw2_memadr", LW, F_ADD, 1'b0, ev(4'd2, 8'b0000_0001, 2'b10, 2'b00, 3'b010, 1'b1));
    add("lw2_memrd",  LW, F_ADD, 1'b0, ev(4'd3, 8'b0100_0000, 2'b00, 2'b00, 3'b010, 1'b1));
    add("lw2_memwb",  LW, F_ADD, 1'b0, ev(4'd4, 8'b0100_0110, 2'b00, 2'b00, 3'b010, 1'b1));

    reset = 1'b1; op = RT; funct = F_ADD; zero = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("during_reset", w_act, fetch_e(1'b0));
    reset = 1'b0;
    #1;
    check("after_reset", w_act, fetch_e(1'b0));

    foreach (tbl[i]) begin
      op = tbl[i].op; funct = tbl[i].funct; zero = tbl[i].zero;
      #1;
      check(tbl[i].name, w_act, tbl[i].exp);
      @(negedge clk);
    end

    // Asynchronous reset while a lw sits in MEMRD
    op = LW; funct = F_ADD; zero = 1'b0;
    #1;
    check("ar_fetch", w_act, fetch_e(1'b1));
    repeat (3) @(negedge clk);
    #1;
    check("ar_memrd", w_act, ev(4'd3, 8'b0100_0000, 2'b00, 2'b00, 3'b010, 1'b1));
    #1;
    reset = 1'b1;
    #1;
    check("ar_async", w_act, fetch_e(1'b0));
    check1("ar_memwrite", memwrite, 1'b0);
    check1("ar_regwrite", regwrite, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("ar_release", w_act, fetch_e(1'b0));

    // R-type with an unsupported funct is illegal as well
    op = RT; funct = F_BAD;
    @(negedge clk);
    #1;
    check("badfunct_decode", w_act, decode_e(1'b0));
    @(negedge clk);
    #1;
    check("badfunct_fetch", w_act, fetch_e(1'b1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running required finished");
    $fatal(1, "timeout");
  end

endmodule
